// File: rtl/l1route_pkg.sv
// Shared constants, encodings and shift-factor helpers for the L1 route source scheduler.
package l1route_pkg;

  localparam int STRIDE_UNIT_SIZE      = 51;
  localparam int STRIDE_WIDTH          = 5;
  localparam int BITWIDTH_SHIFT_FACTOR = $clog2(STRIDE_UNIT_SIZE - 1);
  localparam int LEN_W                 = 4;
  localparam int QSN_LATENCY           = 2;
  localparam int SHIFT_W               = STRIDE_WIDTH * BITWIDTH_SHIFT_FACTOR;

  // First illegal shift value for one stride group.
  localparam logic [BITWIDTH_SHIFT_FACTOR-1:0] SHIFT_LIMIT = BITWIDTH_SHIFT_FACTOR'(STRIDE_UNIT_SIZE);

  localparam logic SRC_IN0 = 1'b0;
  localparam logic SRC_IN1 = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Replace every out-of-range stride field by zero.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] sf);
    logic [SHIFT_W-1:0] r;
    r = sf;
    for (int k = 0; k < STRIDE_WIDTH; k++) begin
      if (sf[k*BITWIDTH_SHIFT_FACTOR +: BITWIDTH_SHIFT_FACTOR] >= SHIFT_LIMIT) begin
        r[k*BITWIDTH_SHIFT_FACTOR +: BITWIDTH_SHIFT_FACTOR] = '0;
      end
    end
    return r;
  endfunction

  // True when any stride field cannot address a 51-entry permutation.
  function automatic logic shift_out_of_range(input logic [SHIFT_W-1:0] sf);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < STRIDE_WIDTH; k++) begin
      if (sf[k*BITWIDTH_SHIFT_FACTOR +: BITWIDTH_SHIFT_FACTOR] >= SHIFT_LIMIT) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/l1route_valid_delay.sv
// Fixed-depth shift register carrying {valid, src, last} alongside the QSN shifter pipeline.
module l1route_valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic valid_i,
  input  logic src_i,
  input  logic last_i,
  output logic valid_o,
  output logic src_o,
  output logic last_o,
  output logic any_valid_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] src_q, src_d;
  logic [DEPTH-1:0] last_q, last_d;

  // Shift every stage one place toward the output each cycle.
  always_comb begin
    valid_d    = valid_q;
    src_d      = src_q;
    last_d     = last_q;
    valid_d[0] = valid_i;
    src_d[0]   = src_i;
    last_d[0]  = last_i;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      src_d[i]   = src_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  // Stage registers; clear flushes the whole pipeline.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      src_q   <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign valid_o     = valid_q[DEPTH-1];
  assign src_o       = src_q[DEPTH-1];
  assign last_o      = last_q[DEPTH-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/l1route_src_scheduler.sv
// Round-robin burst arbiter and beat sequencer for the shared-input multi-source L1 route.
// Handshake: a request is accepted in the cycle where reqN_valid_i & reqN_ready_o; ready is a
// combinational grant offered only in IDLE (unheld) or on the unheld last beat of a burst, and
// the requester must keep valid and its fields stable until accepted.
import l1route_pkg::*;

module l1route_src_scheduler (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [SHIFT_W-1:0] req0_shift_i,
  input  logic [LEN_W-1:0]   req0_len_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [SHIFT_W-1:0] req1_shift_i,
  input  logic [LEN_W-1:0]   req1_len_i,
  input  logic               hold_i,
  output logic               sw_in_src_o,
  output logic [SHIFT_W-1:0] shift_factor_o,
  output logic               beat_rd0_o,
  output logic               beat_rd1_o,
  output logic               issue_valid_o,
  output logic [LEN_W-1:0]   beat_idx_o,
  output logic               out_valid_o,
  output logic               out_src_o,
  output logic               out_last_o,
  output logic               busy_o,
  output logic               err_o
);

  state_e             state_q, state_d;
  logic               rr_q, rr_d;
  logic               src_q, src_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               err_q, err_d;

  logic               issue, last_beat, window, contested;
  logic               grant0, grant1, accept, grant_src;
  logic [SHIFT_W-1:0] acc_shift;
  logic               pipe_any_valid;

  // Grant window, round-robin arbitration, and next burst/FSM state.
  always_comb begin
    issue     = (state_q == ST_ISSUE) && !hold_i;
    last_beat = issue && (cnt_q == len_q);
    window    = ((state_q == ST_IDLE) && !hold_i) || last_beat;
    contested = req0_valid_i && req1_valid_i;
    grant0    = window && req0_valid_i && (!req1_valid_i || (rr_q == SRC_IN0));
    grant1    = window && req1_valid_i && (!req0_valid_i || (rr_q == SRC_IN1));
    accept    = grant0 || grant1;
    grant_src = grant1 ? SRC_IN1 : SRC_IN0;
    acc_shift = grant1 ? req1_shift_i : req0_shift_i;

    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    err_d   = err_q;

    if (accept) begin
      state_d = ST_ISSUE;
      src_d   = grant_src;
      len_d   = grant1 ? req1_len_i : req0_len_i;
      cnt_d   = '0;
      shift_d = clamp_shift(acc_shift);
      err_d   = err_q | shift_out_of_range(acc_shift);
      if (contested) rr_d = ~grant_src;
    end else if (last_beat) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (issue) begin
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  // Scheduler state registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= SRC_IN0;
      src_q   <= SRC_IN0;
      len_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      err_q   <= err_d;
    end
  end

  l1route_valid_delay #(
    .DEPTH (QSN_LATENCY)
  ) u_valid_delay (
    .clk         (sys_clk),
    .clr         (rst),
    .valid_i     (issue),
    .src_i       (src_q),
    .last_i      (last_beat),
    .valid_o     (out_valid_o),
    .src_o       (out_src_o),
    .last_o      (out_last_o),
    .any_valid_o (pipe_any_valid)
  );

  assign req0_ready_o   = grant0;
  assign req1_ready_o   = grant1;
  assign sw_in_src_o    = src_q;
  assign shift_factor_o = shift_q;
  assign issue_valid_o  = issue;
  assign beat_rd0_o     = issue && (src_q == SRC_IN0);
  assign beat_rd1_o     = issue && (src_q == SRC_IN1);
  assign beat_idx_o     = cnt_q;
  assign busy_o         = (state_q != ST_IDLE) || pipe_any_valid;
  assign err_o          = err_q;

endmodule

// File: doc/l1route_src_scheduler.md
Name: l1route_src_scheduler

Overview:
Sequencer/arbiter for the column-wise multi-source L1 route (5 stride groups, 51-wide QSN barrel shifters, 2:1 shared input mux).
- Accepts burst requests from two message sources (src0 -> in0 ports, src1 -> in1 ports), arbitrates round-robin, and drives the shared source-select and per-stride shift factors for the whole burst.
- Tracks the shifter pipeline latency and emits a tagged output-valid stream for the downstream VNU/CNU buffers.

Parameters:
STRIDE_UNIT_SIZE, 51, permutation length per stride group
STRIDE_WIDTH, 5, number of stride groups
BITWIDTH_SHIFT_FACTOR, $clog2(STRIDE_UNIT_SIZE-1), shift factor width per stride (6)
LEN_W, 4, burst length field width; burst = len_i+1 beats (1..16)
QSN_LATENCY, 2, cycles from shift/select issue to valid shifter output (>=1)

Ports:
sys_clk  in  1  clock
rst  in  1  synchronous reset, active-high
req0_valid_i  in  1  src0 burst request
req0_ready_o  out  1  src0 request accepted when valid&ready
req0_shift_i  in  STRIDE_WIDTH*BITWIDTH_SHIFT_FACTOR  src0 shift factors, stride k at [k*BW +: BW]
req0_len_i  in  LEN_W  src0 beats minus one
req1_valid_i / req1_ready_o / req1_shift_i / req1_len_i  same as src0, for src1
hold_i  in  1  downstream stall: suppress beat issue
sw_in_src_o  out  1  shared mux select (0 = in0, 1 = in1)
shift_factor_o  out  STRIDE_WIDTH*BITWIDTH_SHIFT_FACTOR  per-stride shift factors to QSN controllers
beat_rd0_o  out  1  pop strobe to src0 message buffer
beat_rd1_o  out  1  pop strobe to src1 message buffer
issue_valid_o  out  1  beat on shifter inputs this cycle
beat_idx_o  out  LEN_W  index of the current beat in the burst
out_valid_o  out  1  shifter output valid (issue_valid_o delayed QSN_LATENCY)
out_src_o  out  1  source tag of out_valid_o beat
out_last_o  out  1  last beat of burst at shifter output
busy_o  out  1  burst in progress or pipeline non-empty
err_o  out  1  sticky: out-of-range shift factor accepted

Behaviour:
- Reset values: all outputs 0; rr pointer = 0 (src0 wins the first tie); FSM = IDLE; delay line cleared.
- FSM states: IDLE, ISSUE.
  - IDLE: ready is combinational grant. Grant = the only valid requester; if both are valid, the requester matching the rr pointer. Accept -> ISSUE next cycle.
  - ISSUE: beats issue while hold_i = 0. The counter counts 0..len. On the last beat with hold_i = 0, readiness/grant is evaluated as in IDLE. A grant goes straight back to ISSUE (zero-bubble back-to-back); otherwise -> IDLE.
- Both readies are 0 in ISSUE except during the unheld last-beat cycle. Readies are never both 1.
- rr pointer flips to the non-granted source on every grant made while both requesters are valid. It is unchanged on an uncontested grant.
- Registered on accept: source, len, and shift factors; these are held constant on sw_in_src_o/shift_factor_o for the whole burst.
  - Any field >= STRIDE_UNIT_SIZE is replaced by 0 and sets err_o (cleared only by rst).
  - In IDLE, sw_in_src_o and shift_factor_o hold their last values.
- Latency: accept at cycle t -> first beat (issue_valid_o = 1, beat_rd<src>_o = 1, beat_idx_o = 0) at t+1. An unheld burst occupies t+1..t+len+1.
- hold_i = 1 during ISSUE: issue_valid_o = 0, beat_rd* = 0, counter and outputs frozen, no accept. Hold in IDLE blocks accept.
- Delay line: {issue_valid, src, last} is shifted QSN_LATENCY stages every cycle, independent of hold_i. out_* equals issue-side values QSN_LATENCY cycles earlier.
- busy_o = (FSM != IDLE) | any delay-line valid.
- rst mid-burst: the burst is abandoned, the delay line is flushed, and out_valid_o is 0 the next cycle. Requesters must re-present.
- len_i = 0 is a single-beat burst: the first beat is also the last, and a new grant may occur in that same cycle.

Decomposition:
- Shared package/header `l1route_pkg` holds: STRIDE_UNIT_SIZE, STRIDE_WIDTH, BITWIDTH_SHIFT_FACTOR, QSN_LATENCY, source encodings SRC_IN0 = 0 / SRC_IN1 = 1, FSM state encodings.
- One natural sub-module, `l1route_valid_delay`: a parameterised-depth shift register for {valid, src, last} with synchronous active-high clear.
- Arbitration and FSM stay in the top.

Test Plan:
- Single request, uncontested:
  - Stimulus: src0 valid, len = 3, shifts {0, 7, 13, 25, 50}, no hold.
  - Required: ready at t; issue_valid_o and beat_rd0_o high t+1..t+4; beat_idx_o 0..3; sw_in_src_o = 0; shift_factor_o stable.
  - Required: out_valid_o t+3..t+6 with out_last_o at t+6; err_o = 0.
- Contention:
  - Stimulus: both sources valid continuously, len = 1 each.
  - Required: grants alternate src0, src1, src0, ...; zero bubbles (issue_valid_o continuously 1); sw_in_src_o toggles every 2 cycles.
- Hold mid-burst:
  - Stimulus: src1 len = 4; hold_i = 1 for 2 cycles after beat 1.
  - Required: beat_idx_o freezes at 1; no beat_rd1_o during hold; 5 beats total; out_valid_o shows a 2-cycle gap.
- Range check:
  - Stimulus: src0 stride 2 = 51, stride 4 = 63.
  - Required: those fields driven as 0; other fields intact; err_o set and stays 1 until rst.
- Reset mid-operation:
  - Stimulus: rst for 1 cycle during beat 2 of a len = 7 burst.
  - Required: next cycle all outputs 0 and busy_o = 0; rr pointer = 0.
- Single-beat chain:
  - Stimulus: src0 and src1 each issue len = 0 repeatedly.
  - Required: one beat per cycle, alternating sources; out_last_o = 1 on every out_valid_o.
